// File: rtl/biriscv_npc_predictor.sv
// Fetch-stage next-PC predictor: direct-mapped BTB, 2-bit BHT and speculative
// return-address stack, trained from registered branch resolutions.
module biriscv_npc_predictor #(
    parameter int BTB_ENTRIES = 16,
    parameter int BHT_ENTRIES = 64,
    parameter int RAS_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_f_i,
    input  logic        pc_accept_i,
    input  logic        flush_i,
    input  logic        branch_request_i,
    input  logic        branch_is_taken_i,
    input  logic        branch_is_not_taken_i,
    input  logic [31:0] branch_source_i,
    input  logic [31:0] branch_pc_i,
    input  logic        branch_is_call_i,
    input  logic        branch_is_ret_i,
    input  logic        branch_is_jmp_i,
    output logic [31:0] next_pc_f_o,
    output logic        next_taken_f_o
);

    localparam int BTB_W = $clog2(BTB_ENTRIES);
    localparam int BHT_W = $clog2(BHT_ENTRIES);
    localparam int RAS_W = $clog2(RAS_DEPTH);
    localparam int TAG_W = 30 - BTB_W;

    logic             btb_valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
    logic [31:0]      btb_target_q [BTB_ENTRIES];
    logic             btb_call_q   [BTB_ENTRIES];
    logic             btb_ret_q    [BTB_ENTRIES];
    logic             btb_jmp_q    [BTB_ENTRIES];
    logic [1:0]       bht_q        [BHT_ENTRIES];
    logic [31:0]      ras_q        [RAS_DEPTH];
    logic [RAS_W-1:0] spec_ptr_q;
    logic [RAS_W-1:0] act_ptr_q;
    logic [RAS_W-1:0] spec_ptr_d;
    logic [RAS_W-1:0] act_ptr_d;

    logic [BTB_W-1:0] f_btb_idx;
    logic [TAG_W-1:0] f_tag;
    logic [BHT_W-1:0] f_bht_idx;
    logic [31:0]      f_pc_inc;
    logic             f_hit;
    logic             f_call;
    logic             f_ret;

    logic [BTB_W-1:0] b_btb_idx;
    logic [TAG_W-1:0] b_tag;
    logic [BHT_W-1:0] b_bht_idx;
    logic [31:0]      b_src_inc;
    logic             commit_taken;
    logic             commit_not_taken;
    logic             commit_call;
    logic             commit_ret;
    logic             spec_push;
    logic             spec_pop;
    logic [RAS_W-1:0] spec_push_idx;
    logic [RAS_W-1:0] act_push_idx;
    logic             unused_bits;

    assign f_btb_idx = pc_f_i[BTB_W+1:2];
    assign f_tag     = pc_f_i[31:BTB_W+2];
    assign f_bht_idx = pc_f_i[BHT_W+1:2];
    assign f_pc_inc  = pc_f_i + 32'd4;

    assign b_btb_idx = branch_source_i[BTB_W+1:2];
    assign b_tag     = branch_source_i[31:BTB_W+2];
    assign b_bht_idx = branch_source_i[BHT_W+1:2];
    assign b_src_inc = branch_source_i + 32'd4;

    assign unused_bits = ^{pc_f_i[1:0], branch_source_i[1:0]};

    always_comb begin
        f_hit          = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_tag);
        f_ret          = f_hit && btb_ret_q[f_btb_idx];
        f_call         = f_hit && btb_call_q[f_btb_idx] && !btb_ret_q[f_btb_idx];
        next_pc_f_o    = f_pc_inc;
        next_taken_f_o = 1'b0;
        if (f_ret) begin
            next_pc_f_o    = ras_q[spec_ptr_q];
            next_taken_f_o = 1'b1;
        end else if (f_hit && (btb_call_q[f_btb_idx] || btb_jmp_q[f_btb_idx] ||
                               bht_q[f_bht_idx][1])) begin
            next_pc_f_o    = btb_target_q[f_btb_idx];
            next_taken_f_o = 1'b1;
        end
    end

    // Taken wins when both outcome flags are raised.
    assign commit_taken     = branch_request_i && branch_is_taken_i;
    assign commit_not_taken = branch_request_i && branch_is_not_taken_i && !branch_is_taken_i;
    assign commit_call      = branch_request_i && branch_is_call_i;
    assign commit_ret       = branch_request_i && branch_is_ret_i && !branch_is_call_i;
    assign spec_push        = pc_accept_i && f_call && !flush_i;
    assign spec_pop         = pc_accept_i && f_ret && !flush_i;
    assign spec_push_idx    = spec_ptr_q + RAS_W'(1);
    assign act_push_idx     = act_ptr_q + RAS_W'(1);

    always_comb begin
        act_ptr_d = act_ptr_q;
        if (commit_call) begin
            act_ptr_d = act_ptr_q + RAS_W'(1);
        end else if (commit_ret) begin
            act_ptr_d = act_ptr_q - RAS_W'(1);
        end
        spec_ptr_d = spec_ptr_q;
        if (flush_i) begin
            spec_ptr_d = act_ptr_d;
        end else if (spec_push) begin
            spec_ptr_d = spec_push_idx;
        end else if (spec_pop) begin
            spec_ptr_d = spec_ptr_q - RAS_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_call_q[i]   <= 1'b0;
                btb_ret_q[i]    <= 1'b0;
                btb_jmp_q[i]    <= 1'b0;
            end
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            spec_ptr_q <= '0;
            act_ptr_q  <= '0;
        end else begin
            spec_ptr_q <= spec_ptr_d;
            act_ptr_q  <= act_ptr_d;
            // Commit repair is issued last so it wins a same-index conflict.
            if (spec_push) begin
                ras_q[spec_push_idx] <= f_pc_inc;
            end
            if (commit_call) begin
                ras_q[act_push_idx] <= b_src_inc;
            end
            if (commit_taken) begin
                btb_valid_q[b_btb_idx]  <= 1'b1;
                btb_tag_q[b_btb_idx]    <= b_tag;
                btb_target_q[b_btb_idx] <= branch_pc_i;
                btb_call_q[b_btb_idx]   <= branch_is_call_i;
                btb_ret_q[b_btb_idx]    <= branch_is_ret_i;
                btb_jmp_q[b_btb_idx]    <= branch_is_jmp_i;
                if (bht_q[b_bht_idx] != 2'b11) begin
                    bht_q[b_bht_idx] <= bht_q[b_bht_idx] + 2'd1;
                end
            end else if (commit_not_taken) begin
                if (bht_q[b_bht_idx] != 2'b00) begin
                    bht_q[b_bht_idx] <= bht_q[b_bht_idx] - 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_biriscv_npc_predictor.sv
// Randomised bench for biriscv_npc_predictor with an array-based reference
// model plus directed scenarios carrying hand-computed expectations.
module tb_biriscv_npc_predictor;

    localparam int BTB_N   = 16;
    localparam int BHT_N   = 64;
    localparam int RAS_D   = 4;
    localparam int BTB_LOG = 4;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] pc_f_i;
    logic        pc_accept_i;
    logic        flush_i;
    logic        branch_request_i;
    logic        branch_is_taken_i;
    logic        branch_is_not_taken_i;
    logic [31:0] branch_source_i;
    logic [31:0] branch_pc_i;
    logic        branch_is_call_i;
    logic        branch_is_ret_i;
    logic        branch_is_jmp_i;
    logic [31:0] next_pc_f_o;
    logic        next_taken_f_o;

    int errors = 0;
    int checks = 0;

    biriscv_npc_predictor #(
        .BTB_ENTRIES(BTB_N),
        .BHT_ENTRIES(BHT_N),
        .RAS_DEPTH  (RAS_D)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .pc_f_i               (pc_f_i),
        .pc_accept_i          (pc_accept_i),
        .flush_i              (flush_i),
        .branch_request_i     (branch_request_i),
        .branch_is_taken_i    (branch_is_taken_i),
        .branch_is_not_taken_i(branch_is_not_taken_i),
        .branch_source_i      (branch_source_i),
        .branch_pc_i          (branch_pc_i),
        .branch_is_call_i     (branch_is_call_i),
        .branch_is_ret_i      (branch_is_ret_i),
        .branch_is_jmp_i      (branch_is_jmp_i),
        .next_pc_f_o          (next_pc_f_o),
        .next_taken_f_o       (next_taken_f_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model state
    bit          m_valid [BTB_N];
    logic [31:0] m_tag   [BTB_N];
    logic [31:0] m_tgt   [BTB_N];
    bit          m_call  [BTB_N];
    bit          m_ret   [BTB_N];
    bit          m_jmp   [BTB_N];
    int          m_bht   [BHT_N];
    logic [31:0] m_ras   [RAS_D];
    int          m_sp;
    int          m_ap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BTB_N; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
            m_call[i] = 0; m_ret[i] = 0; m_jmp[i] = 0;
        end
        for (int i = 0; i < BHT_N; i++) m_bht[i] = 1;
        for (int i = 0; i < RAS_D; i++) m_ras[i] = '0;
        m_sp = 0;
        m_ap = 0;
    endtask

    function automatic void model_predict(input logic [31:0] pc, output logic [31:0] npc,
                                          output logic tk, output logic hit,
                                          output logic cl, output logic rt);
        int unsigned bi = (pc >> 2) % BTB_N;
        int unsigned hi = (pc >> 2) % BHT_N;
        hit = m_valid[bi] && (m_tag[bi] == (pc >> (2 + BTB_LOG)));
        rt  = hit && m_ret[bi];
        cl  = hit && m_call[bi] && !m_ret[bi];
        npc = pc + 32'd4;
        tk  = 1'b0;
        if (rt) begin
            npc = m_ras[m_sp];
            tk  = 1'b1;
        end else if (hit && (m_call[bi] || m_jmp[bi] || m_bht[hi] >= 2)) begin
            npc = m_tgt[bi];
            tk  = 1'b1;
        end
    endfunction

    task automatic model_step();
        logic [31:0] npc;
        logic tk, hit, cl, rt, taken, ntaken;
        int ap_n, sp_n;
        int unsigned bi, hi;
        model_predict(pc_f_i, npc, tk, hit, cl, rt);
        taken  = branch_is_taken_i;
        ntaken = branch_is_not_taken_i && !branch_is_taken_i;
        ap_n = m_ap;
        if (branch_request_i && branch_is_call_i) ap_n = (m_ap + 1) % RAS_D;
        else if (branch_request_i && branch_is_ret_i) ap_n = (m_ap + RAS_D - 1) % RAS_D;
        sp_n = m_sp;
        if (flush_i) sp_n = ap_n;
        else if (pc_accept_i && rt) sp_n = (m_sp + RAS_D - 1) % RAS_D;
        else if (pc_accept_i && cl) begin
            sp_n = (m_sp + 1) % RAS_D;
            m_ras[sp_n] = pc_f_i + 32'd4;
        end
        if (branch_request_i && branch_is_call_i)
            m_ras[(m_ap + 1) % RAS_D] = branch_source_i + 32'd4;
        m_sp = sp_n;
        m_ap = ap_n;
        bi = (branch_source_i >> 2) % BTB_N;
        hi = (branch_source_i >> 2) % BHT_N;
        if (branch_request_i && taken) begin
            m_valid[bi] = 1;
            m_tag[bi]   = branch_source_i >> (2 + BTB_LOG);
            m_tgt[bi]   = branch_pc_i;
            m_call[bi]  = branch_is_call_i;
            m_ret[bi]   = branch_is_ret_i;
            m_jmp[bi]   = branch_is_jmp_i;
            if (m_bht[hi] < 3) m_bht[hi] = m_bht[hi] + 1;
        end else if (branch_request_i && ntaken) begin
            if (m_bht[hi] > 0) m_bht[hi] = m_bht[hi] - 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            if (rst_ni) model_step();
        end
    end

    // Compare process: outputs are combinational and meaningful every cycle.
    initial begin
        logic [31:0] npc;
        logic tk, hit, cl, rt;
        forever begin
            @(negedge clk_i);
            model_predict(pc_f_i, npc, tk, hit, cl, rt);
            chk("model_next_pc", next_pc_f_o, npc);
            chk("model_taken", {31'd0, next_taken_f_o}, {31'd0, tk});
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        pc_accept_i = 0; flush_i = 0; branch_request_i = 0;
        branch_is_taken_i = 0; branch_is_not_taken_i = 0;
        branch_source_i = '0; branch_pc_i = '0;
        branch_is_call_i = 0; branch_is_ret_i = 0; branch_is_jmp_i = 0;
    endtask

    task automatic set_br(input logic tk, input logic [31:0] src, input logic [31:0] tgt,
                          input logic c, input logic r, input logic j);
        branch_request_i = 1; branch_is_taken_i = tk; branch_is_not_taken_i = !tk;
        branch_source_i = src; branch_pc_i = tgt;
        branch_is_call_i = c; branch_is_ret_i = r; branch_is_jmp_i = j;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        int unsigned sel = $urandom_range(0, 63);
        if (sel == 0) return 32'hFFFF_FFFC;
        case (sel % 3)
            0:       base = 32'h8000_0000;
            1:       base = 32'h8000_0040;
            default: base = 32'h0000_1000;
        endcase
        return base + 32'd4 * $urandom_range(0, 15);
    endfunction

    initial begin : stim
        logic [31:0] ret_seq [5];
        int unsigned cls;
        ret_seq[0] = 32'h3034; ret_seq[1] = 32'h3030; ret_seq[2] = 32'h302C;
        ret_seq[3] = 32'h3028; ret_seq[4] = 32'h3034;

        model_reset();
        rst_ni = 0;
        idle();
        pc_f_i = 32'h8000_0100;
        #2;
        chk("reset_next_pc", next_pc_f_o, 32'h8000_0104);
        chk("reset_taken", {31'd0, next_taken_f_o}, 32'd0);
        tick(); tick();
        rst_ni = 1;

        tick();
        pc_f_i = 32'h8000_0100; #1;
        chk("cold_fetch", next_pc_f_o, 32'h8000_0104);
        pc_f_i = 32'hFFFF_FFFC; #1;
        chk("pc_wrap", next_pc_f_o, 32'h0000_0000);

        // BTB allocate; same-cycle lookup still sees the old contents
        tick();
        pc_f_i = 32'h8000_0100;
        set_br(1, 32'h8000_0100, 32'h8000_0200, 0, 0, 1); #1;
        chk("alloc_same_cycle", next_pc_f_o, 32'h8000_0104);
        tick(); idle(); #1;
        chk("alloc_next_pc", next_pc_f_o, 32'h8000_0200);
        chk("alloc_taken", {31'd0, next_taken_f_o}, 32'd1);

        // BHT hysteresis at 0x80000040
        tick(); set_br(1, 32'h8000_0040, 32'h8000_0300, 0, 0, 0);
        tick(); set_br(1, 32'h8000_0040, 32'h8000_0300, 0, 0, 0);
        tick(); idle(); pc_f_i = 32'h8000_0040; #1;
        chk("bht_cnt3", next_pc_f_o, 32'h8000_0300);
        tick(); set_br(0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
        tick(); idle(); #1;
        chk("bht_cnt2", next_pc_f_o, 32'h8000_0300);
        tick(); set_br(0, 32'h8000_0040, 32'h8000_0044, 0, 0, 0);
        tick(); idle(); #1;
        chk("bht_cnt1", next_pc_f_o, 32'h8000_0044);
        chk("bht_cnt1_taken", {31'd0, next_taken_f_o}, 32'd0);

        // Call / return
        tick(); set_br(1, 32'h1000, 32'h2000, 1, 0, 0);
        tick(); set_br(1, 32'h2010, 32'h1004, 0, 1, 0);
        tick(); idle(); flush_i = 1;
        tick(); idle(); pc_f_i = 32'h1000; pc_accept_i = 1; #1;
        chk("call_predict", next_pc_f_o, 32'h2000);
        tick(); idle(); pc_f_i = 32'h2010; #1;
        chk("ret_from_ras", next_pc_f_o, 32'h1004);

        // RAS_DEPTH+1 nested calls: oldest return address overwritten
        for (int k = 0; k < 5; k++) begin
            tick(); set_br(1, 32'h3020 + 32'(4 * k), 32'h5000, 1, 0, 0);
        end
        tick(); idle(); flush_i = 1;
        tick(); idle();
        for (int k = 0; k < 5; k++) begin
            pc_f_i = 32'h3020 + 32'(4 * k); pc_accept_i = 1; #1;
            chk("nest_call", next_pc_f_o, 32'h5000);
            tick();
        end
        pc_f_i = 32'h2010; pc_accept_i = 1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("nest_ret", next_pc_f_o, ret_seq[k]);
            tick();
        end

        // Flush recovery of speculative pointer
        idle(); flush_i = 1;
        tick(); idle();
        pc_f_i = 32'h3020; pc_accept_i = 1; tick();
        pc_f_i = 32'h3024; pc_accept_i = 1; tick();
        idle(); pc_f_i = 32'h2010; #1;
        chk("spec_two_push", next_pc_f_o, 32'h3028);
        flush_i = 1;
        tick(); idle(); #1;
        chk("flush_restore", next_pc_f_o, 32'h3030);
        // Flush with a committed call and a blocked speculative push, same index
        pc_f_i = 32'h3020; pc_accept_i = 1; flush_i = 1;
        set_br(1, 32'h4000, 32'h5000, 1, 0, 0);
        tick(); idle(); pc_f_i = 32'h2010; #1;
        chk("flush_with_commit", next_pc_f_o, 32'h4004);

        // Asynchronous reset between edges
        tick(); pc_f_i = 32'h3020; #1;
        chk("pre_reset_taken", {31'd0, next_taken_f_o}, 32'd1);
        #1; rst_ni = 0; model_reset(); #1;
        chk("async_rst_taken", {31'd0, next_taken_f_o}, 32'd0);
        chk("async_rst_pc", next_pc_f_o, 32'h3024);
        tick(); tick(); rst_ni = 1;
        tick();
        pc_f_i = 32'h3020; #1;
        chk("post_rst_a", next_pc_f_o, 32'h3024);
        pc_f_i = 32'h8000_0100; #1;
        chk("post_rst_b", next_pc_f_o, 32'h8000_0104);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (n == 1502) rst_ni = 1;
            idle();
            pc_f_i      = rand_pc();
            pc_accept_i = $urandom_range(0, 3) != 0;
            flush_i     = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 1) == 1) begin
                cls = $urandom_range(0, 7);
                branch_request_i = 1;
                branch_source_i  = rand_pc();
                branch_is_call_i = cls == 0;
                branch_is_ret_i  = cls == 1;
                branch_is_jmp_i  = cls == 2;
                if (cls < 3) branch_is_taken_i = 1;
                else         branch_is_taken_i = $urandom_range(0, 1);
                branch_is_not_taken_i = !branch_is_taken_i || ($urandom_range(0, 31) == 0);
                branch_pc_i = branch_is_taken_i ? rand_pc() : branch_source_i + 32'd4;
            end else if ($urandom_range(0, 3) == 0) begin
                branch_is_taken_i = 1;
                branch_is_call_i  = 1;
                branch_source_i   = rand_pc();
                branch_pc_i       = rand_pc();
            end
            if (n == 1500) begin
                #2; rst_ni = 0; model_reset();
            end
        end

        tick(); idle(); #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biriscv_npc_predictor.md
Name: biriscv_npc_predictor

Overview:
- Next-PC predictor in the fetch stage, downstream of the execute branch unit.
- Consumes the registered branch-resolution outputs (request, taken/not-taken, source, target, call/ret/jmp class) one cycle after execute.
- Trains a direct-mapped BTB, a 2-bit BHT and a speculative return-address stack (RAS).
- From the current fetch PC it produces the predicted next fetch PC in the same cycle.

Parameters:
- BTB_ENTRIES, 16, number of direct-mapped BTB entries (power of 2, ≥4); index pc[log2(BTB_ENTRIES)+1:2].
- BHT_ENTRIES, 64, number of 2-bit counters (power of 2); index pc[log2(BHT_ENTRIES)+1:2].
- RAS_DEPTH, 4, return-address-stack depth (power of 2, ≥2).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- pc_f_i  in  32  current fetch PC (word aligned).
- pc_accept_i  in  1  fetch consumed pc_f_i this cycle; gates speculative RAS push/pop.
- flush_i  in  1  pipeline redirect after a mispredict; restores speculative RAS pointer.
- branch_request_i  in  1  a branch/jump resolved this cycle.
- branch_is_taken_i  in  1  resolved taken.
- branch_is_not_taken_i  in  1  resolved not taken.
- branch_source_i  in  32  PC of the resolved branch.
- branch_pc_i  in  32  resolved next PC (target if taken).
- branch_is_call_i  in  1  resolved call (rd==x1).
- branch_is_ret_i  in  1  resolved return (jalr x1, imm 0).
- branch_is_jmp_i  in  1  resolved other unconditional jump.
- next_pc_f_o  out  32  predicted next fetch PC.
- next_taken_f_o  out  1  prediction is a taken redirect.

Behaviour:
- Reset (async, rst_ni=0):
  - all BTB valid bits 0;
  - BHT counters 2'b01 (weakly not taken);
  - RAS entries 0;
  - spec_ptr = act_ptr = 0.
  - Outputs are combinational; during and right after reset next_pc_f_o = pc_f_i+4 and next_taken_f_o = 0.
- BTB entry fields: valid, tag = pc[31:log2(BTB_ENTRIES)+2], target[31:0], is_call, is_ret, is_jmp.
- Lookup (combinational, zero latency): hit = valid[idx(pc_f_i)] && tag match.
  - hit && is_ret → next_pc = ras[spec_ptr], taken=1.
  - hit && (is_call || is_jmp) → next_pc = target, taken=1.
  - hit && conditional && bht[idx][1] → next_pc = target, taken=1.
  - otherwise next_pc = pc_f_i+4 (32-bit wrap, 0xFFFFFFFC → 0), taken=0.
- Speculative RAS, only when pc_accept_i=1 && hit:
  - predicted call: spec_ptr ← spec_ptr+1 (mod RAS_DEPTH) and ras[spec_ptr+1] ← pc_f_i+4.
  - predicted ret: spec_ptr ← spec_ptr-1 (mod RAS_DEPTH).
  - Overflow silently overwrites the oldest entry; underflow wraps. No empty/full flags.
- Committed RAS pointer, on branch_request_i:
  - call: act_ptr+1, and ras[act_ptr+1] ← branch_source_i+4 (repair write).
  - ret: act_ptr-1.
- flush_i: spec_ptr ← act_ptr of the next state, i.e. including any commit update in the same cycle. flush_i takes priority over a speculative push/pop in that cycle.
- Same-cycle RAS write conflict (speculative push and commit repair to the same index): the commit value is written.
- BTB update on branch_request_i && branch_is_taken_i:
  - entry idx(branch_source_i) ← {valid=1, tag, branch_pc_i, call, ret, jmp}, replacing any prior occupant.
  - Not-taken resolutions never allocate or invalidate.
- BHT update on branch_request_i, at idx(branch_source_i):
  - taken → saturating increment (max 3);
  - not taken → saturating decrement (min 0).
  - Unconditional jumps also train.
- Read/write ordering: a lookup in the cycle of an update to the same index sees the old contents; the new contents are visible the next cycle.
- branch_request_i=0: no BTB/BHT/act_ptr change, regardless of the other branch_* inputs.
- Both taken and not-taken asserted is illegal; the block treats it as taken.
- Reset asserted mid-operation clears state immediately, independent of clk_i.

Test Plan:
- Cold fetch: after reset, pc_f_i=0x80000100 → next_pc_f_o=0x80000104, next_taken_f_o=0.
- BTB allocate: resolve taken jmp source=0x80000100 target=0x80000200. Next cycle pc_f_i=0x80000100 → next_pc=0x80000200, taken=1. Same-cycle lookup during the update still gives 0x80000104.
- BHT hysteresis: conditional at 0x80000040 resolved taken twice → counter 3, predicts taken. One not-taken → counter 2, still taken. Second not-taken → counter 1, predicts 0x80000044.
- Call/return:
  - Allocate call at 0x1000→0x2000 and ret at 0x2010 (target 0x1004).
  - Fetch-accept 0x1000 then fetch 0x2010 → next_pc=0x1004 from RAS.
  - Nest RAS_DEPTH+1 calls → oldest return address overwritten, pointer wraps.
- Flush recovery: speculatively push two calls (spec_ptr=2, act_ptr=0), assert flush_i → spec_ptr=0. Flush in the same cycle as a committed call → spec_ptr=1.
- Async reset: assert rst_ni=0 between clock edges with a trained BTB → next_taken_f_o drops to 0 immediately; after release all lookups give pc+4.
